// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage F/D/E/M/W pipeline: stall/flush
// generation, forwarding selects, MDU busy sequencing and a saturating stall counter.
module hazard_ctrl #(
  parameter int MDCYCLES = 8,
  parameter int CNTW     = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      rsD,
  input  logic [4:0]      rtD,
  input  logic [4:0]      rsE,
  input  logic [4:0]      rtE,
  input  logic [4:0]      writeregE,
  input  logic [4:0]      writeregM,
  input  logic [4:0]      writeregW,
  input  logic            regwriteE,
  input  logic            regwriteM,
  input  logic            regwriteW,
  input  logic            memtoregE,
  input  logic            memtoregM,
  input  logic            branchD,
  input  logic            jumpD,
  input  logic            pcsrcD,
  input  logic            mdstartE,
  input  logic            mduseD,
  output logic            stallF,
  output logic            stallD,
  output logic            flushD,
  output logic            flushE,
  output logic            forwardAD,
  output logic            forwardBD,
  output logic [1:0]      forwardAE,
  output logic [1:0]      forwardBE,
  output logic            mdbusy,
  output logic            mddone,
  output logic [CNTW-1:0] stallcount
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [7:0] CNT_LOAD = 8'(MDCYCLES - 1);

  logic [1:0]      r_state;
  logic [7:0]      r_cnt;
  logic [CNTW-1:0] r_stallcount;

  logic w_lwstall;
  logic w_branchstall;
  logic w_mdstall;
  logic w_stall;

  assign w_lwstall = memtoregE & ((rsD == rtE) | (rtD == rtE));

  assign w_branchstall = branchD &
                         ((regwriteE & ((writeregE == rsD) | (writeregE == rtD))) |
                          (memtoregM & ((writeregM == rsD) | (writeregM == rtD))));

  // A D-stage MDU user must wait both while the unit is busy and in the cycle its op starts.
  assign w_mdstall = mduseD & ((r_state == BUSY) | mdstartE);

  // Reset is folded in so every control output is quiet while reset is held.
  assign w_stall = reset & (w_lwstall | w_branchstall | w_mdstall);

  assign stallF = w_stall;
  assign stallD = w_stall;
  assign flushE = w_stall;
  assign flushD = reset & (pcsrcD | jumpD) & ~w_stall;

  // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    forwardAE = 2'b00;
    forwardBE = 2'b00;
    forwardAD = 1'b0;
    forwardBD = 1'b0;
    if (reset) begin
      if (rsE != 5'd0 && rsE == writeregM && regwriteM)      forwardAE = 2'b10;
      else if (rsE != 5'd0 && rsE == writeregW && regwriteW) forwardAE = 2'b01;

      if (rtE != 5'd0 && rtE == writeregM && regwriteM)      forwardBE = 2'b10;
      else if (rtE != 5'd0 && rtE == writeregW && regwriteW) forwardBE = 2'b01;

      forwardAD = (rsD != 5'd0) && (rsD == writeregM) && regwriteM;
      forwardBD = (rtD != 5'd0) && (rtD == writeregM) && regwriteM;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= 8'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (mdstartE) begin
            r_state <= BUSY;
            r_cnt   <= CNT_LOAD;
          end
        end
        BUSY: begin
          // A start request here is a protocol violation and leaves the count alone.
          if (r_cnt == 8'd0) r_state <= DONE;
          else               r_cnt   <= r_cnt - 8'd1;
        end
        DONE: begin
          if (mdstartE) begin
            r_state <= BUSY;
            r_cnt   <= CNT_LOAD;
          end else begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mdbusy = (r_state == BUSY);
  assign mddone = (r_state == DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stallcount <= '0;
    end else if (w_stall && (r_stallcount != {CNTW{1'b1}})) begin
      r_stallcount <= r_stallcount + CNTW'(1);
    end
  end

  assign stallcount = r_stallcount;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (MDCYCLES=4, CNTW=4): reset, forwarding, stalls,
// MDU sequencing, back-to-back/abort and counter saturation.
module tb_hazard_ctrl;

  logic       clk;
  logic       reset;
  logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic       regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
  logic       branchD, jumpD, pcsrcD, mdstartE, mduseD;
  logic       stallF, stallD, flushD, flushE, forwardAD, forwardBD;
  logic [1:0] forwardAE, forwardBE;
  logic       mdbusy, mddone;
  logic [3:0] stallcount;

  int n_vec = 0;
  int n_err = 0;

  hazard_ctrl #(.MDCYCLES(4), .CNTW(4)) dut (
    .clk(clk), .reset(reset),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .memtoregE(memtoregE), .memtoregM(memtoregM),
    .branchD(branchD), .jumpD(jumpD), .pcsrcD(pcsrcD),
    .mdstartE(mdstartE), .mduseD(mduseD),
    .stallF(stallF), .stallD(stallD), .flushD(flushD), .flushE(flushE),
    .forwardAD(forwardAD), .forwardBD(forwardBD),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .mdbusy(mdbusy), .mddone(mddone), .stallcount(stallcount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    rsD = 5'd0; rtD = 5'd0; rsE = 5'd0; rtE = 5'd0;
    writeregE = 5'd0; writeregM = 5'd0; writeregW = 5'd0;
    regwriteE = 1'b0; regwriteM = 1'b0; regwriteW = 1'b0;
    memtoregE = 1'b0; memtoregM = 1'b0;
    branchD = 1'b0; jumpD = 1'b0; pcsrcD = 1'b0;
    mdstartE = 1'b0; mduseD = 1'b0;
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    clear_inputs();
    reset = 1'b0;
    #1;
    reset = 1'b1;
    #1;
  endtask

  initial begin
    // Reset with a load-use hazard and a forwarding match present
    clear_inputs();
    reset = 1'b0;
    memtoregE = 1'b1; rtE = 5'd5; rsD = 5'd5; pcsrcD = 1'b1;
    rsE = 5'd3; writeregM = 5'd3; regwriteM = 1'b1;
    #2;
    chk("rst_stallF", stallF, 1'b0);
    chk("rst_stallD", stallD, 1'b0);
    chk("rst_flushE", flushE, 1'b0);
    chk("rst_flushD", flushD, 1'b0);
    chk("rst_fwdAE", forwardAE, 2'b00);
    chk("rst_mdbusy", mdbusy, 1'b0);
    chk("rst_mddone", mddone, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst_stallcount", stallcount, 4'd0);

    reset = 1'b1;
    #1;
    chk("rel_stallF", stallF, 1'b1);
    chk("rel_stallD", stallD, 1'b1);
    chk("rel_flushE", flushE, 1'b1);
    chk("rel_flushD_blocked", flushD, 1'b0);
    chk("rel_fwdAE", forwardAE, 2'b10);
    @(negedge clk);
    chk("rel_stallcount1", stallcount, 4'd1);

    // Forwarding
    clear_inputs();
    #1;
    chk("idle_stallD", stallD, 1'b0);
    rsE = 5'd3; rtE = 5'd3; writeregM = 5'd3; regwriteM = 1'b1; writeregW = 5'd3; regwriteW = 1'b1;
    #1;
    chk("fwd_AE_M", forwardAE, 2'b10);
    chk("fwd_BE_M", forwardBE, 2'b10);
    regwriteM = 1'b0;
    #1;
    chk("fwd_AE_W", forwardAE, 2'b01);
    chk("fwd_BE_W", forwardBE, 2'b01);
    rsE = 5'd4; rtE = 5'd0; writeregM = 5'd5; regwriteM = 1'b1; writeregW = 5'd4;
    #1;
    chk("fwd_AE_W_only", forwardAE, 2'b01);
    rsE = 5'd0; rtE = 5'd0; writeregM = 5'd0; writeregW = 5'd0; regwriteM = 1'b1; regwriteW = 1'b1;
    #1;
    chk("fwd_AE_r0", forwardAE, 2'b00);
    chk("fwd_BE_r0", forwardBE, 2'b00);
    chk("fwd_AD_r0", forwardAD, 1'b0);
    rsD = 5'd9; writeregM = 5'd9;
    #1;
    chk("fwd_AD_M", forwardAD, 1'b1);
    chk("fwd_BD_nomatch", forwardBD, 1'b0);
    rtD = 5'd9;
    #1;
    chk("fwd_BD_M", forwardBD, 1'b1);
    regwriteM = 1'b0;
    #1;
    chk("fwd_AD_nowrite", forwardAD, 1'b0);

    // Branch and load-use hazards
    clear_inputs();
    branchD = 1'b1; rsD = 5'd7; writeregE = 5'd7; regwriteE = 1'b1; pcsrcD = 1'b1;
    #1;
    chk("br_E_stallD", stallD, 1'b1);
    chk("br_E_flushE", flushE, 1'b1);
    chk("br_E_flushD", flushD, 1'b0);
    regwriteE = 1'b0; rsD = 5'd0; rtD = 5'd7; writeregM = 5'd7; memtoregM = 1'b1;
    #1;
    chk("br_M_stallF", stallF, 1'b1);
    memtoregM = 1'b0;
    #1;
    chk("br_clear_stallF", stallF, 1'b0);
    chk("br_clear_flushD", flushD, 1'b1);
    branchD = 1'b0; pcsrcD = 1'b0; jumpD = 1'b1;
    #1;
    chk("jump_flushD", flushD, 1'b1);
    jumpD = 1'b0; memtoregE = 1'b1; rtE = 5'd6; rtD = 5'd6; rsD = 5'd1;
    #1;
    chk("lw_rt_stallD", stallD, 1'b1);
    rtD = 5'd2;
    #1;
    chk("lw_none_stallD", stallD, 1'b0);

    // MDU single operation with a dependent D-stage user
    reset_pulse();
    @(negedge clk);
    mdstartE = 1'b1; mduseD = 1'b1;
    #1;
    chk("md_start_stallD", stallD, 1'b1);
    chk("md_start_busy", mdbusy, 1'b0);
    @(negedge clk);
    mdstartE = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("md_busy%0d", i), mdbusy, 1'b1);
      chk($sformatf("md_busy_stall%0d", i), stallD, 1'b1);
      chk($sformatf("md_busy_done%0d", i), mddone, 1'b0);
      @(negedge clk);
    end
    #1;
    chk("md_done", mddone, 1'b1);
    chk("md_done_busy", mdbusy, 1'b0);
    chk("md_done_stallD", stallD, 1'b0);
    chk("md_stallcount", stallcount, 4'd5);
    @(negedge clk);
    #1;
    chk("md_idle_done", mddone, 1'b0);
    chk("md_idle_busy", mdbusy, 1'b0);
    chk("md_idle_stallD", stallD, 1'b0);

    // Back-to-back restart from DONE, with an ignored start while BUSY
    mduseD = 1'b0; mdstartE = 1'b1;
    @(negedge clk);
    mdstartE = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("b2b_done1", mddone, 1'b1);
    mdstartE = 1'b1;
    @(negedge clk);
    #1;
    chk("b2b_rebusy", mdbusy, 1'b1);
    chk("b2b_rebusy_done", mddone, 1'b0);
    @(negedge clk);
    mdstartE = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("b2b_last_busy", mdbusy, 1'b1);
    @(negedge clk);
    #1;
    chk("b2b_done2", mddone, 1'b1);
    @(negedge clk);
    #1;
    chk("b2b_idle", mdbusy | mddone, 1'b0);

    // Abort by reset mid-BUSY
    mdstartE = 1'b1;
    @(negedge clk);
    mdstartE = 1'b0;
    @(negedge clk);
    #1;
    chk("abort_busy", mdbusy, 1'b1);
    reset = 1'b0;
    #1;
    chk("abort_idle", mdbusy, 1'b0);
    chk("abort_done", mddone, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("abort_nodone%0d", i), mddone | mdbusy, 1'b0);
    end

    // Stall counter saturation
    reset_pulse();
    memtoregE = 1'b1; rsD = 5'd5; rtE = 5'd5;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("sat_cnt%0d", k), stallcount, (k > 15) ? 32'd15 : 32'(k));
    end
    clear_inputs();
    repeat (2) @(negedge clk);
    #1;
    chk("sat_hold", stallcount, 4'd15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
